// File: rtl/osc_sweep_pkg.sv
// Shared types and helpers for the oscillation sweep monitor.
//   state_t   : sweep controller states
//   result_t  : one per-vector verdict {vec, osc, flag, mismatch}
//   win_cnt_w : width needed by the settling-window counters
// The vec field of result_t is RES_VEC_W bits wide. This is the default
// stimulus width of osc_sweep_monitor.
package osc_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    OBSERVE = 3'd2,
    REPORT  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int RES_VEC_W = 8;

  typedef struct packed {
    logic [RES_VEC_W-1:0] vec;
    logic                 osc;
    logic                 flag;
    logic                 mismatch;
  } result_t;

  // Wide enough to hold the larger of the two window limits.
  function automatic int win_cnt_w(input int max_cycles, input int stable_cycles);
    int m;
    m = (max_cycles > stable_cycles) ? max_cycles : stable_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/osc_stability_window.sv
// Settling detector for one held stimulus vector.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_clear         : restart the window (asserted in APPLY)
//   i_en            : window is observing this cycle (OBSERVE)
//   i_obs           : internal-net snapshot
//   o_stable_hit    : this cycle makes STABLE_CYCLES consecutive repeats
//   o_timeout_hit   : this cycle is observation cycle MAX_CYCLES
// Both hits are evaluated on the counter values this cycle produces. That
// way a verdict fires on the very cycle that satisfies it.
module osc_stability_window
  import osc_sweep_pkg::*;
#(
  parameter int OBS_W         = 14,
  parameter int STABLE_CYCLES = 100,
  parameter int MAX_CYCLES    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [OBS_W-1:0] i_obs,
  output logic             o_stable_hit,
  output logic             o_timeout_hit
);

  localparam int CNT_W = win_cnt_w(MAX_CYCLES, STABLE_CYCLES);

  logic [OBS_W-1:0] r_prev;
  logic [CNT_W-1:0] r_run;
  logic [CNT_W-1:0] r_total;
  logic             r_first;
  logic [CNT_W-1:0] w_run_nxt;
  logic [CNT_W-1:0] w_total_nxt;
  logic             w_same;

  assign w_same = (i_obs == r_prev);

  always_comb begin
    w_total_nxt = r_total + CNT_W'(1);
    if (r_first)
      w_run_nxt = '0;
    else if (w_same)
      w_run_nxt = r_run + CNT_W'(1);
    else
      w_run_nxt = '0;
  end

  // The first observation cycle only primes r_prev. It can never be a stable hit.
  assign o_stable_hit  = i_en && !r_first && (w_run_nxt == CNT_W'(STABLE_CYCLES));
  assign o_timeout_hit = i_en && (w_total_nxt == CNT_W'(MAX_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_run   <= '0;
      r_total <= '0;
      r_first <= 1'b1;
    end else if (i_en) begin
      r_run   <= w_run_nxt;
      r_total <= w_total_nxt;
      r_first <= 1'b0;
    end
  end

  // Snapshot register: reload on the first cycle and on every change.
  always_ff @(posedge clk) begin
    if (i_en && (r_first || !w_same))
      r_prev <= i_obs;
  end

endmodule

// File: rtl/osc_sweep_monitor.sv
// Stimulus sequencer and stability monitor for a loop circuit under test.
// It steps vec_out through every vector and holds each one while the
// settling window watches obs_in. It then reports stable/oscillating
// together with the LUT prediction sampled on the verdict cycle.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : sweep start pulse (accepted in IDLE/DONE only)
//   busy, done            : sweep in progress / sweep complete
//   vec_out               : stimulus to the circuit inputs
//   obs_in                : internal-net snapshot from the circuit
//   flag_in               : LUT oscillation prediction for vec_out
//   res_valid/res_ready   : result handshake
//   res_vec/osc/flag/mismatch : latched per-vector result
//   osc_count, mismatch_count : sweep statistics
module osc_sweep_monitor
  import osc_sweep_pkg::*;
#(
  parameter int VEC_W         = RES_VEC_W,
  parameter int OBS_W         = 14,
  parameter int STABLE_CYCLES = 100,
  parameter int MAX_CYCLES    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] vec_out,
  input  logic [OBS_W-1:0] obs_in,
  input  logic             flag_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [VEC_W-1:0] res_vec,
  output logic             res_osc,
  output logic             res_flag,
  output logic             res_mismatch,
  output logic [VEC_W:0]   osc_count,
  output logic [VEC_W:0]   mismatch_count
);

  localparam int CW = VEC_W + 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [VEC_W-1:0] r_vec;
  result_t          r_res;
  logic [CW-1:0]    r_osc_cnt;
  logic [CW-1:0]    r_mm_cnt;

  logic w_start_ok;
  logic w_apply;
  logic w_observe;
  logic w_report;
  logic w_stable_hit;
  logic w_timeout_hit;
  logic w_verdict;
  logic w_verdict_osc;
  logic w_verdict_mm;
  logic w_hs;
  logic w_last_vec;

  osc_stability_window #(
    .OBS_W         (OBS_W),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_CYCLES    (MAX_CYCLES)
  ) u_window (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (w_apply),
    .i_en          (w_observe),
    .i_obs         (obs_in),
    .o_stable_hit  (w_stable_hit),
    .o_timeout_hit (w_timeout_hit)
  );

  assign w_start_ok    = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_verdict     = w_stable_hit || w_timeout_hit;
  // A stable hit wins over a coincident timeout.
  assign w_verdict_osc = !w_stable_hit;
  assign w_verdict_mm  = w_verdict_osc ^ flag_in;
  assign w_hs          = w_report && res_ready;
  assign w_last_vec    = (r_vec == '1);

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (w_start_ok) w_state_nxt = APPLY;
      APPLY:      w_state_nxt = OBSERVE;
      OBSERVE:    if (w_verdict) w_state_nxt = REPORT;
      REPORT:     if (res_ready) w_state_nxt = w_last_vec ? DONE : APPLY;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs. res_valid is a pure function of the state register,
  // so there is no path from res_ready back to res_valid.
  always_comb begin
    w_apply   = (r_state == APPLY);
    w_observe = (r_state == OBSERVE);
    w_report  = (r_state == REPORT);
    busy      = w_apply || w_observe || w_report;
    done      = (r_state == DONE);
    res_valid = w_report;
  end

  // Vector counter, result register and sweep statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec     <= '0;
      r_res     <= '0;
      r_osc_cnt <= '0;
      r_mm_cnt  <= '0;
    end else begin
      if (w_start_ok) begin
        r_vec     <= '0;
        r_osc_cnt <= '0;
        r_mm_cnt  <= '0;
      end else if (w_hs && !w_last_vec) begin
        r_vec <= r_vec + VEC_W'(1);
      end
      if (w_verdict) begin
        r_res.vec      <= RES_VEC_W'(r_vec);
        r_res.osc      <= w_verdict_osc;
        r_res.flag     <= flag_in;
        r_res.mismatch <= w_verdict_mm;
        if (w_verdict_osc) r_osc_cnt <= r_osc_cnt + CW'(1);
        if (w_verdict_mm)  r_mm_cnt  <= r_mm_cnt + CW'(1);
      end
    end
  end

  assign vec_out        = r_vec;
  assign res_vec        = VEC_W'(r_res.vec);
  assign res_osc        = r_res.osc;
  assign res_flag       = r_res.flag;
  assign res_mismatch   = r_res.mismatch;
  assign osc_count      = r_osc_cnt;
  assign mismatch_count = r_mm_cnt;

endmodule

// File: tb/tb_osc_sweep_monitor.sv
// Scoreboard bench for osc_sweep_monitor (STABLE_CYCLES=4, MAX_CYCLES=20).
// The driver pushes the expected result of each vector when it applies
// that vector's stimulus. The monitor pops and compares on every handshake.
module tb_osc_sweep_monitor;

  localparam int VW = 8;
  localparam int OW = 14;
  localparam int SC = 4;
  localparam int MC = 20;
  localparam int LAT_STABLE = SC + 2;
  localparam int LAT_OSC    = MC + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [VW-1:0] vec_out;
  logic [OW-1:0] obs_in;
  logic          flag_in;
  logic          res_valid;
  logic          res_ready;
  logic [VW-1:0] res_vec;
  logic          res_osc;
  logic          res_flag;
  logic          res_mismatch;
  logic [VW:0]   osc_count;
  logic [VW:0]   mismatch_count;

  osc_sweep_monitor #(
    .VEC_W(VW), .OBS_W(OW), .STABLE_CYCLES(SC), .MAX_CYCLES(MC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .vec_out(vec_out), .obs_in(obs_in), .flag_in(flag_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_vec(res_vec),
    .res_osc(res_osc), .res_flag(res_flag), .res_mismatch(res_mismatch),
    .osc_count(osc_count), .mismatch_count(mismatch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] vec;
    logic          osc;
    logic          flag;
    logic          mm;
    int            lat;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int mode = 1;         // 1: all stable, 2: mixed scenario sweep
  int cnt = 0;          // cycles since APPLY of current vector
  int exp_idx = 0;
  int n_results = 0;
  logic hs_n = 1'b0;
  logic start_n = 1'b0;
  logic valid_prev = 1'b0;
  int lat_seen = 0;
  logic [VW-1:0] held_vec;
  logic [2:0]    held_bits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Hand-derived expectation for vector idx under the current mode.
  function automatic exp_t make_exp(input int m, input int idx);
    exp_t e;
    e.vec = VW'(idx);
    e.osc = 1'b0; e.flag = 1'b0; e.mm = 1'b0; e.lat = LAT_STABLE;
    if (m == 2) begin
      if (idx >= 'h32 && idx <= 'h3F) begin
        e.osc = 1'b1; e.flag = 1'b1; e.lat = LAT_OSC;
      end else if (idx == 'h40) begin
        e.lat = LAT_OSC;
      end else if (idx == 'h10) begin
        e.flag = 1'b1; e.mm = 1'b1;
      end
    end
    return e;
  endfunction

  // Circuit model / stimulus driver
  always @(posedge clk) begin
    #1;
    if (hs_n || start_n) cnt = 0; else cnt = cnt + 1;
    if (mode == 1) begin
      obs_in  = 14'h2AAA;
      flag_in = 1'b0;
    end else if (vec_out >= 8'h32 && vec_out <= 8'h3F) begin
      obs_in  = OW'(cnt & 1);
      flag_in = 1'b1;
    end else if (vec_out == 8'h40) begin
      // toggles until OBSERVE cycle MC-SC, then holds a fresh value
      obs_in  = (cnt >= MC - SC) ? 14'h3FFF : OW'(cnt & 1);
      flag_in = 1'b0;
    end else begin
      obs_in  = OW'(vec_out) ^ 14'h1555;
      flag_in = (vec_out == 8'h10);
    end
    res_ready = !(mode == 2 && vec_out == 8'd5 && cnt < LAT_STABLE + 50);
    if (cnt == 0 && busy) begin
      exp_q.push_back(make_exp(mode, exp_idx));
      exp_idx++;
    end
  end

  // Result monitor
  always @(negedge clk) begin
    exp_t e;
    hs_n    = res_valid && res_ready;
    start_n = start && !busy;
    if (res_valid) begin
      if (!valid_prev) begin
        lat_seen  = cnt;
        held_vec  = res_vec;
        held_bits = {res_osc, res_flag, res_mismatch};
      end else begin
        chk("hold_res_vec", res_vec, held_vec);
        chk("hold_res_bits", {res_osc, res_flag, res_mismatch}, held_bits);
      end
      chk("vec_out_held", vec_out, res_vec);
      if (res_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: actual vec=%0h required none", res_vec);
        end else begin
          e = exp_q.pop_front();
          chk("res_vec", res_vec, e.vec);
          chk("res_osc", res_osc, e.osc);
          chk("res_flag", res_flag, e.flag);
          chk("res_mismatch", res_mismatch, e.mm);
          chk("res_latency", lat_seen, e.lat);
          n_results++;
        end
      end
    end
    valid_prev = res_valid;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_vec_out"}, vec_out, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_vec"}, res_vec, 0);
    chk({tag, "_res_osc"}, res_osc, 0);
    chk({tag, "_res_flag"}, res_flag, 0);
    chk({tag, "_res_mismatch"}, res_mismatch, 0);
    chk({tag, "_osc_count"}, osc_count, 0);
    chk({tag, "_mismatch_count"}, mismatch_count, 0);
  endtask

  task automatic do_start();
    exp_idx   = 0;
    n_results = 0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
  endtask

  task automatic wait_vec(input logic [VW-1:0] target, input int limit);
    int n;
    n = 0;
    while (vec_out !== target && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= limit) chk("wait_vec_timeout", vec_out, target);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= limit) chk("wait_done_timeout", done, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; res_ready = 1'b1; obs_in = '0; flag_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Sweep 1: everything settles, exact sweep length
    mode = 1;
    do_start();
    wait_done(3000, n);
    chk("sweep1_cycles_to_done", n, 256 * (SC + 3));
    chk("sweep1_results", n_results, 256);
    chk("sweep1_osc_count", osc_count, 0);
    chk("sweep1_mismatch_count", mismatch_count, 0);
    chk("sweep1_queue_empty", exp_q.size(), 0);
    chk("sweep1_busy_low", busy, 0);

    // Sweep 2: oscillating block, boundary vector, flag mismatch,
    // backpressure on vector 5 and an ignored start pulse
    mode = 2;
    do_start();
    wait_vec(8'h20, 5000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(10000, n);
    chk("sweep2_results", n_results, 256);
    chk("sweep2_osc_count", osc_count, 14);
    chk("sweep2_mismatch_count", mismatch_count, 1);
    chk("sweep2_queue_empty", exp_q.size(), 0);

    // Sweep 3: reset aborts mid-sweep
    do_start();
    wait_vec(8'h80, 5000);
    chk("sweep3_osc_count_at_80", osc_count, 14);
    chk("sweep3_mismatch_count_at_80", mismatch_count, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("abort");
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("abort_stays_idle_busy", busy, 0);
    chk("abort_stays_idle_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/osc_sweep_monitor.md
# osc_sweep_monitor

Synthesizable stimulus sequencer and stability monitor that sits directly upstream of the loop-circuit-under-test and its oscillation LUT. It sweeps every input vector, holds each one on the circuit, and watches a snapshot of internal nets for settling. It reports a per-vector verdict (stable/oscillating) and whether that verdict agrees with the LUT flag. This replaces the delay-based testbench sweep with clocked hardware usable on FPGA or in cycle-based simulation.

## Interface
Parameters:
- VEC_W, 8, width of stimulus vector driven into the circuit
- OBS_W, 14, width of observed internal-net snapshot
- STABLE_CYCLES, 100, consecutive unchanged cycles required to declare "stable"
- MAX_CYCLES, 1000, observation budget per vector; exceeding it means "oscillating"

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins sweep from vector 0 (ignored unless IDLE/DONE)
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  high in DONE; cleared by the next accepted start or rst
- vec_out  out  VEC_W  stimulus to circuit inputs
- obs_in  in  OBS_W  internal-net snapshot from circuit (assumed synchronized upstream)
- flag_in  in  1  LUT oscillation prediction for the current vec_out
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_vec  out  VEC_W  vector the result belongs to
- res_osc  out  1  1 = measured oscillating
- res_flag  out  1  flag_in sampled at verdict
- res_mismatch  out  1  res_osc XOR res_flag
- osc_count  out  VEC_W+1  vectors judged oscillating this sweep
- mismatch_count  out  VEC_W+1  vectors with mismatch this sweep

## Operation
- States: IDLE, APPLY, OBSERVE, REPORT, DONE.
- IDLE/DONE + start: vec_out<=0, counts<=0, done<=0, go APPLY.
- APPLY (1 cycle): vec_out stable. Clear stable_run and total counter. Go OBSERVE.
- OBSERVE:
  - First cycle loads prev<=obs_in with stable_run=0.
  - Each later cycle: obs_in==prev increments stable_run; otherwise stable_run<=0 and prev<=obs_in.
  - total increments every cycle.
  - stable_run==STABLE_CYCLES gives verdict osc=0.
  - Otherwise total==MAX_CYCLES gives verdict osc=1.
  - If both occur in the same cycle, stable wins.
  - On verdict: latch res_* (flag_in sampled that cycle), update counts, go REPORT.
- REPORT: res_valid=1 and res_* held until res_valid&&res_ready.
  - On handshake, if vec_out==2^VEC_W-1, go DONE.
  - Else vec_out<=vec_out+1 and go APPLY.
- Counters never wrap: max value 2^VEC_W fits VEC_W+1 bits.
- start while busy is ignored. rst at any point aborts the sweep immediately.

## Timing
- Reset values: state IDLE; busy=0, done=0, vec_out=0, res_valid=0, res_vec=0, res_osc=0, res_flag=0, res_mismatch=0, osc_count=0, mismatch_count=0.
- start at cycle t: APPLY at t+1, busy=1 from t+1.
- Constant obs_in: verdict after STABLE_CYCLES+1 OBSERVE cycles. res_valid rises the next cycle. With res_ready=1, each vector costs STABLE_CYCLES+3 cycles.
- Oscillating vector: verdict on OBSERVE cycle MAX_CYCLES; res_valid the cycle after.
- Full sweep (all stable, ready=1): 2^VEC_W·(STABLE_CYCLES+3) cycles from APPLY to DONE entry.
- res_valid never drops without handshake. res_* are stable while valid. No combinational path from res_ready to res_valid.

## Structure
- Package osc_sweep_pkg: state enum (IDLE, APPLY, OBSERVE, REPORT, DONE), result struct {vec, osc, flag, mismatch}, and a clog2-derived counter-width function for MAX_CYCLES/STABLE_CYCLES.
- Sub-module osc_stability_window: prev register, stable_run and total counters, and verdict outputs (stable_hit, timeout_hit). Parameterized by OBS_W, STABLE_CYCLES, MAX_CYCLES. Top level holds the FSM, vector counter, result register and statistics.

## Test plan
- obs_in constant, flag_in=0, res_ready=1, small params (STABLE=4, MAX=20): 256 results, all res_osc=0. osc_count=0, mismatch_count=0. DONE reached exactly 256·7 cycles after APPLY.
- obs_in toggling bit0 every cycle for vectors 0x32–0x3F, flag_in=1 for those vectors: those 14 results have res_osc=1, res_mismatch=0, and arrive MAX+1 cycles after APPLY. osc_count=14.
- Boundary: obs_in changes once at OBSERVE cycle MAX−STABLE, then holds. Verdict lands on cycle MAX with both conditions true → res_osc=0.
- Backpressure: res_ready low for 50 cycles on vector 5. res_valid and res_vec=5 are held, and vec_out stays 5 throughout.
- start pulsed mid-sweep is ignored: vec_out sequence is unbroken. rst at vector 0x80: next cycle all outputs are at reset values and state is IDLE.
- flag_in=1 while obs_in is constant for vector 0x10 only: that result has res_mismatch=1 and final mismatch_count=1.
